// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared FSM encoding, word width and PC constants for the PC sequencer
package pc_seq_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] WORD_ZERO = '0;
  localparam logic [WORD_W-1:0] PC_INC = 32'd4;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC priority select (pending, jmp, branch, pc+4)
// Ports: pend_i/pend_addr_i pending redirect, jmp_i/jmp_target_i jump,
//        br_i/br_target_i taken branch, pc_i current PC, next_pc_o selected PC.
module pc_next_sel
  import pc_seq_pkg::*;
(
  input  logic              pend_i,
  input  logic [WORD_W-1:0] pend_addr_i,
  input  logic              jmp_i,
  input  logic [WORD_W-1:0] jmp_target_i,
  input  logic              br_i,
  input  logic [WORD_W-1:0] br_target_i,
  input  logic [WORD_W-1:0] pc_i,
  output logic [WORD_W-1:0] next_pc_o
);
  // pc + 4 wraps naturally at 32 bits
  assign next_pc_o = pend_i ? pend_addr_i :
                     jmp_i  ? jmp_target_i :
                     br_i   ? br_target_i : pc_i + PC_INC;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC sequencer with IDLE/FETCH/HOLD FSM, redirect capture and squash
// Ports: clk, rst (sync, active-low), stall, jmp/jmp_target, br_taken/br_target,
//        imem_req/imem_addr/imem_ack fetch handshake, pc, pc_valid, misalign.
// Macro ALIGN_CHECK_EN: trap misaligned targets to EXC_VECTOR and pulse misalign.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        misalign
);
`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif
  state_t state_q;
  logic [WORD_W-1:0] pc_q, redir_addr_q, next_pc, pc_d, live_tgt;
  logic redir_pend_q, misalign_q, live, bad, redirect;
  assign live     = jmp | br_taken;
  assign redirect = live | redir_pend_q;
  // jmp beats br_taken when both are raised
  assign live_tgt = jmp ? jmp_target : br_target;
  pc_next_sel u_sel (
    .pend_i      (redir_pend_q),
    .pend_addr_i (redir_addr_q),
    .jmp_i       (jmp),
    .jmp_target_i(jmp_target),
    .br_i        (br_taken),
    .br_target_i (br_target),
    .pc_i        (pc_q),
    .next_pc_o   (next_pc)
  );
  assign bad  = ALIGN_EN && (next_pc[1:0] != 2'b00);
  assign pc_d = bad ? EXC_VECTOR : next_pc;
  // outputs are gated by rst so they read 0 for the whole reset cycle
  assign imem_req  = rst && state_q == FETCH;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign pc_valid  = imem_req && imem_ack && !redirect;
  assign misalign  = rst && misalign_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_VECTOR;
      redir_pend_q <= 1'b0;
      redir_addr_q <= WORD_ZERO;
      misalign_q   <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      unique case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            // a redirect squashes the fetch and ignores stall
            if (redirect || !stall) begin
              pc_q         <= pc_d;
              misalign_q   <= bad;
              redir_pend_q <= 1'b0;
            end
            state_q <= (!redirect && stall) ? HOLD : FETCH;
          end else if (live) begin
            redir_pend_q <= 1'b1;
            redir_addr_q <= live_tgt;
          end
        end
        HOLD: begin
          if (!stall) begin
            pc_q         <= pc_d;
            misalign_q   <= bad;
            redir_pend_q <= 1'b0;
            state_q      <= FETCH;
          end else if (live) begin
            redir_pend_q <= 1'b1;
            redir_addr_q <= live_tgt;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven directed bench for pc_sequencer
module tb_pc_sequencer;
  logic clk = 1'b0, rst = 1'b0, stall = 1'b0, jmp = 1'b0, br_taken = 1'b0, imem_ack = 1'b0;
  logic [31:0] jmp_target = '0, br_target = '0;
  logic imem_req, pc_valid, misalign;
  logic [31:0] imem_addr, pc;
  int checks = 0, errors = 0;
  typedef struct {
    logic r, s, a, j;
    logic [31:0] jt;
    logic b;
    logic [31:0] bt;
    logic req;
    logic [31:0] addr;
    logic v;
  } vec_t;
  vec_t tv[29];
  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .jmp(jmp), .jmp_target(jmp_target),
    .br_taken(br_taken), .br_target(br_target), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .pc(pc), .pc_valid(pc_valid),
    .misalign(misalign)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic r, s, a, j, logic [31:0] jt, logic b, logic [31:0] bt,
                              logic req, logic [31:0] addr, logic v);
    mk = '{r: r, s: s, a: a, j: j, jt: jt, b: b, bt: bt, req: req, addr: addr, v: v};
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic drive(logic r, s, a, j, logic [31:0] jt, logic b, logic [31:0] bt);
    @(negedge clk);
    rst = r; stall = s; imem_ack = a; jmp = j; jmp_target = jt; br_taken = b; br_target = bt;
    #2;
  endtask
  initial begin
    //          r  s  a  j  jt            b  bt            req addr          v
    tv[0]  = mk(0, 0, 0, 0, 0,            0, 0,            0, 32'h0,         0);
    tv[1]  = mk(1, 0, 1, 0, 0,            0, 0,            0, 32'h0,         0);
    tv[2]  = mk(1, 0, 1, 0, 0,            0, 0,            1, 32'h0,         1);
    tv[3]  = mk(1, 0, 1, 0, 0,            0, 0,            1, 32'h4,         1);
    tv[4]  = mk(1, 0, 1, 0, 0,            0, 0,            1, 32'h8,         1);
    tv[5]  = mk(1, 0, 1, 0, 0,            0, 0,            1, 32'hC,         1);
    tv[6]  = mk(0, 0, 1, 0, 0,            0, 0,            0, 32'h10,        0);
    tv[7]  = mk(1, 0, 1, 0, 0,            0, 0,            0, 32'h0,         0);
    tv[8]  = mk(1, 0, 1, 0, 0,            0, 0,            1, 32'h0,         1);
    tv[9]  = mk(1, 1, 1, 0, 0,            0, 0,            1, 32'h4,         1);
    tv[10] = mk(1, 1, 1, 0, 0,            0, 0,            0, 32'h4,         0);
    tv[11] = mk(1, 1, 0, 0, 0,            0, 0,            0, 32'h4,         0);
    tv[12] = mk(1, 0, 0, 0, 0,            0, 0,            0, 32'h4,         0);
    tv[13] = mk(1, 0, 1, 1, 32'h100,      1, 32'h200,      1, 32'h8,         0);
    tv[14] = mk(1, 0, 0, 0, 0,            1, 32'h40,       1, 32'h100,       0);
    tv[15] = mk(1, 0, 0, 0, 0,            0, 0,            1, 32'h100,       0);
    tv[16] = mk(1, 0, 1, 0, 0,            0, 0,            1, 32'h100,       0);
    tv[17] = mk(1, 0, 1, 0, 0,            0, 0,            1, 32'h40,        1);
    tv[18] = mk(1, 0, 0, 1, 32'h300,      0, 0,            1, 32'h44,        0);
    tv[19] = mk(1, 0, 0, 0, 0,            1, 32'h500,      1, 32'h44,        0);
    tv[20] = mk(1, 0, 1, 0, 0,            0, 0,            1, 32'h44,        0);
    tv[21] = mk(1, 0, 1, 0, 0,            0, 0,            1, 32'h500,       1);
    tv[22] = mk(1, 1, 1, 0, 0,            0, 0,            1, 32'h504,       1);
    tv[23] = mk(1, 1, 0, 1, 32'h600,      0, 0,            0, 32'h504,       0);
    tv[24] = mk(1, 0, 0, 0, 0,            0, 0,            0, 32'h504,       0);
    tv[25] = mk(1, 0, 1, 0, 0,            0, 0,            1, 32'h600,       1);
    tv[26] = mk(1, 1, 1, 1, 32'hFFFF_FFFC, 0, 0,           1, 32'h604,       0);
    tv[27] = mk(1, 0, 1, 0, 0,            0, 0,            1, 32'hFFFF_FFFC, 1);
    tv[28] = mk(1, 0, 1, 0, 0,            0, 0,            1, 32'h0,         1);
    @(posedge clk);
    for (int i = 0; i < 29; i++) begin
      drive(tv[i].r, tv[i].s, tv[i].a, tv[i].j, tv[i].jt, tv[i].b, tv[i].bt);
      chk($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, tv[i].req});
      chk($sformatf("v%0d imem_addr", i), imem_addr, tv[i].addr);
      chk($sformatf("v%0d pc_valid", i), {31'b0, pc_valid}, {31'b0, tv[i].v});
      chk($sformatf("v%0d misalign", i), {31'b0, misalign}, 32'h0);
    end
    // long ack wait: request held, no delivery, until ack arrives
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      chk($sformatf("wait%0d imem_req", i), {31'b0, imem_req}, 32'h1);
      chk($sformatf("wait%0d pc_valid", i), {31'b0, pc_valid}, 32'h0);
      chk($sformatf("wait%0d imem_addr", i), imem_addr, 32'h4);
    end
    drive(1, 0, 1, 0, 0, 0, 0);
    chk("late_ack pc_valid", {31'b0, pc_valid}, 32'h1);
    // misaligned jump at pc=8
    drive(1, 0, 1, 1, 32'h102, 0, 0);
    chk("mis_jmp pc_valid", {31'b0, pc_valid}, 32'h0);
    chk("mis_jmp misalign", {31'b0, misalign}, 32'h0);
    drive(1, 0, 0, 0, 0, 0, 0);
`ifdef ALIGN_CHECK_EN
    chk("mis_trap misalign", {31'b0, misalign}, 32'h1);
    chk("mis_trap imem_addr", imem_addr, 32'h80);
`else
    chk("mis_trap misalign", {31'b0, misalign}, 32'h0);
    chk("mis_trap imem_addr", imem_addr, 32'h102);
`endif
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("mis_after misalign", {31'b0, misalign}, 32'h0);
    // reset mid-fetch while ack is high
    drive(0, 0, 1, 0, 0, 0, 0);
    chk("rst_mid imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst_mid pc_valid", {31'b0, pc_valid}, 32'h0);
    drive(1, 0, 1, 0, 0, 0, 0);
    chk("rst_after pc", pc, 32'h0);
    chk("rst_after imem_req", {31'b0, imem_req}, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
